// File: rtl/fact_pkg.sv
// ---------------------------------------------------------------------------
// fact_pkg
//   Shared definitions for the iterative factorial engine. The control unit
//   and the datapath (fact_dp) both use these state encodings, so the two
//   blocks always agree on what each curr_state value means.
// ---------------------------------------------------------------------------
package fact_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
  localparam logic [STATE_W-1:0] ST_MUL   = 3'd2;
  localparam logic [STATE_W-1:0] ST_DEC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

endpackage : fact_pkg

// File: rtl/fact_mul.sv
// ---------------------------------------------------------------------------
// fact_mul
//   Combinational OUT_W x SIZE unsigned multiplier. It returns the low OUT_W
//   bits of the full product, plus a flag that is set when any of the upper
//   SIZE bits are nonzero, meaning the product did not fit in OUT_W bits.
// Ports
//   a      in   OUT_W   running product
//   b      in   SIZE    down-counter value
//   lo     out  OUT_W   product truncated to OUT_W bits
//   hi_nz  out  1       upper part of the full product is nonzero
// ---------------------------------------------------------------------------
module fact_mul #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic [OUT_W-1:0] a,
  input  logic [SIZE-1:0]  b,
  output logic [OUT_W-1:0] lo,
  output logic             hi_nz
);

  logic [OUT_W+SIZE-1:0] full;

  // Both operands are widened first, so the multiply produces every bit of
  // the result and the overflow detection is exact.
  assign full  = (OUT_W+SIZE)'(a) * (OUT_W+SIZE)'(b);
  assign lo    = full[OUT_W-1:0];
  assign hi_nz = |full[OUT_W+SIZE-1:OUT_W];

endmodule : fact_mul

// File: rtl/fact_dp.sv
// ---------------------------------------------------------------------------
// fact_dp
//   Datapath for the iterative factorial engine. It holds the down-counter,
//   the running product, the sticky overflow flag and the latched result.
//   Register updates are decoded from the control unit's curr_state. The
//   block returns proceed, which tells the control unit whether to run
//   another multiply/decrement pass.
// Ports
//   clk           in   1       rising-edge clock
//   rst_n         in   1       asynchronous active-low reset
//   n_in          in   SIZE    operand, sampled on the init edge only
//   curr_state    in   3       control-unit state (fact_pkg encodings)
//   init          in   1       load strobe, honoured only in ST_IDLE
//   done          in   1       completion strobe, honoured only in ST_DONE
//   proceed       out  1       combinational loop-continue flag
//   result        out  OUT_W   latched n! (low OUT_W bits)
//   result_valid  out  1       result holds a completed computation
//   overflow      out  1       result was truncated
// ---------------------------------------------------------------------------
module fact_dp
  import fact_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SIZE-1:0]    n_in,
  input  logic [STATE_W-1:0] curr_state,
  input  logic               init,
  input  logic               done,
  output logic               proceed,
  output logic [OUT_W-1:0]   result,
  output logic               result_valid,
  output logic               overflow
);

  logic [SIZE-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] prod_q, prod_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;

  logic [OUT_W-1:0] mul_lo;
  logic             mul_hi_nz;

  fact_mul #(
    .SIZE  (SIZE),
    .OUT_W (OUT_W)
  ) u_mul (
    .a     (prod_q),
    .b     (cnt_q),
    .lo    (mul_lo),
    .hi_nz (mul_hi_nz)
  );

  // Once overflow is set the loop exits at the next CHECK. After a reset,
  // cnt is 0, which holds proceed low while the control unit drains.
  assign proceed = (curr_state == ST_CHECK) && (cnt_q > SIZE'(1)) && !ovf_q;

  always_comb begin
    // NOTE: each _d starts as its _q, so any path that does not assign a
    // register holds it. This also avoids inferring latches.
    cnt_d          = cnt_q;
    prod_d         = prod_q;
    ovf_d          = ovf_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;

    case (curr_state)
      ST_IDLE: begin
        if (init) begin
          cnt_d          = n_in;
          prod_d         = OUT_W'(1);
          ovf_d          = 1'b0;
          busy_d         = 1'b1;
          result_valid_d = 1'b0;
        end
      end
      ST_CHECK: ;
      ST_MUL: begin
        prod_d = mul_lo;
        ovf_d  = ovf_q | mul_hi_nz;
      end
      ST_DEC: begin
        cnt_d = cnt_q - SIZE'(1);
      end
      ST_DONE: begin
        // The busy_q guard stops a control unit that is draining after a
        // datapath reset from latching a bogus result.
        if (done && busy_q) begin
          result_d       = prod_q;
          overflow_d     = ovf_q;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state flops use non-blocking assignments only. Reset is
  // asynchronous and clears every register, because none of them may hold a
  // stale value after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      prod_q         <= '0;
      ovf_q          <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      prod_q         <= prod_d;
      ovf_q          <= ovf_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule : fact_dp

// File: tb/tb_fact_dp.sv
// ---------------------------------------------------------------------------
// tb_fact_dp
//   Pairs fact_dp with a behavioural control unit. A reference model computes
//   the expected result, overflow flag and completion edge for each start.
//   One compare process checks the DUT outputs against the model on every
//   cycle. Directed cases pin known values; randomized operands follow them.
// ---------------------------------------------------------------------------
module tb_fact_dp;
  import fact_pkg::*;

  localparam int SIZE  = 8;
  localparam int OUT_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SIZE-1:0]    n_in = '0;
  logic [STATE_W-1:0] cu_state = ST_IDLE;
  logic               go = 1'b0;
  logic               init, done, proceed;
  logic [OUT_W-1:0]   result;
  logic               result_valid, overflow;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fact_dp #(.SIZE(SIZE), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .n_in         (n_in),
    .curr_state   (cu_state),
    .init         (init),
    .done         (done),
    .proceed      (proceed),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  // Behavioural control unit. It has no reset, like the real one.
  assign init = go && (cu_state == ST_IDLE);
  assign done = (cu_state == ST_DONE);

  always @(posedge clk) begin
    case (cu_state)
      ST_IDLE:  cu_state <= go ? ST_CHECK : ST_IDLE;
      ST_CHECK: cu_state <= proceed ? ST_MUL : ST_DONE;
      ST_MUL:   cu_state <= ST_DEC;
      ST_DEC:   cu_state <= ST_CHECK;
      default:  cu_state <= ST_IDLE;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: multiply n*(n-1)*... down to 2, keeping the low 32 bits
  // and stopping after the first multiply whose product does not fit.
  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [31:0] mults;
  } exp_t;

  function automatic exp_t model(input int n);
    exp_t e;
    longint unsigned p, full;
    p = 1;
    e.ovf = 1'b0;
    e.mults = 0;
    for (int k = n; k >= 2; k--) begin
      full = p * longint'(k);
      e.mults = e.mults + 1;
      p = full & 64'hFFFF_FFFF;
      if ((full >> 32) != 0) begin
        e.ovf = 1'b1;
        break;
      end
    end
    e.res = p[31:0];
    return e;
  endfunction

  // Each multiply costs a CHECK/MUL/DEC pass, then come the final CHECK and DONE.
  function automatic int latency(input int n);
    exp_t e;
    e = model(n);
    return 3 * int'(e.mults) + 2;
  endfunction

  // Model of the datapath outputs. It is armed at the init edge and fires
  // at the predicted completion edge.
  int          edge_cnt = 0;
  int          due = 0;
  bit          pend;
  exp_t        p_exp;
  logic [31:0] m_res;
  logic        m_valid, m_ovf;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res   <= '0;
      m_valid <= 1'b0;
      m_ovf   <= 1'b0;
      pend    <= 1'b0;
    end else if (cu_state == ST_IDLE && init) begin
      p_exp   <= model(int'(n_in));
      due     <= edge_cnt + latency(int'(n_in));
      pend    <= 1'b1;
      m_valid <= 1'b0;
    end else if (pend && edge_cnt == due) begin
      m_valid <= 1'b1;
      m_res   <= p_exp.res;
      m_ovf   <= p_exp.ovf;
      pend    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      check("result", 64'(result), 64'(m_res));
      check("result_valid", 64'(result_valid), 64'(m_valid));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (cu_state != ST_CHECK) check("proceed_outside_check", 64'(proceed), 64'd0);
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      if (cu_state == ST_IDLE) break;
      @(negedge clk);
    end
    if (k == 200) check("cu_idle_timeout", 64'(cu_state), 64'(ST_IDLE));
  endtask

  // Starts one computation and returns the number of edges from the init
  // edge until result_valid is seen high.
  task automatic run(input int n, input bit change_n, output int lat);
    wait_idle();
    @(negedge clk);
    n_in = SIZE'(n);
    go   = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    check("valid_cleared_on_init", 64'(result_valid), 64'd0);
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      lat++;
      #1;
      if (change_n && lat == 2) n_in = SIZE'(200);
      if (result_valid) break;
    end
    if (lat >= 2000) check("valid_timeout", 64'(result_valid), 64'd1);
    wait_idle();
  endtask

  initial begin
    int lat;
    int n;
    exp_t e;

    // The model's own arithmetic, pinned by hand.
    e = model(5);   check("model_5", 64'(e.res), 64'd120);
    e = model(13);  check("model_13", 64'(e.res), 64'd1932053504);
    check("model_13_ovf", 64'(e.ovf), 64'd1);
    check("model_lat_5", 64'(latency(5)), 64'd14);

    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_proceed", 64'(proceed), 64'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    run(5, 1'b0, lat);
    check("lat_5", 64'(lat), 64'd14);
    check("res_5", 64'(result), 64'd120);
    check("ovf_5", 64'(overflow), 64'd0);

    run(0, 1'b0, lat);
    check("lat_0", 64'(lat), 64'd2);
    check("res_0", 64'(result), 64'd1);
    run(1, 1'b0, lat);
    check("lat_1", 64'(lat), 64'd2);
    check("res_1", 64'(result), 64'd1);

    run(12, 1'b0, lat);
    check("res_12", 64'(result), 64'd479001600);
    check("ovf_12", 64'(overflow), 64'd0);
    run(13, 1'b0, lat);
    check("res_13", 64'(result), 64'd1932053504);
    check("ovf_13", 64'(overflow), 64'd1);
    check("lat_13", 64'(lat), 64'd38);

    run(6, 1'b1, lat);
    check("res_6_nin_change", 64'(result), 64'd720);

    // Back-to-back: the old result holds while valid is low, then updates.
    run(4, 1'b0, lat);
    check("res_4", 64'(result), 64'd24);
    run(3, 1'b0, lat);
    check("res_3_after_4", 64'(result), 64'd6);

    // Reset during MUL of n=7. rst_n is held across the DEC edge, so cnt
    // stays 0 when CHECK is reached.
    run(4, 1'b0, lat);
    wait_idle();
    @(negedge clk);
    n_in = SIZE'(7);
    go   = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int k = 0; k < 20 && cu_state != ST_MUL; k++) @(negedge clk);
    check("reached_mul", 64'(cu_state), 64'(ST_MUL));
    #1 rst_n = 1'b0;
    #1;
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();
    check("drain_valid_low", 64'(result_valid), 64'd0);
    run(3, 1'b0, lat);
    check("res_3_after_rst", 64'(result), 64'd6);

    for (int i = 0; i < 60; i++) begin
      n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 13)) : int'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(n, 1'b0, lat);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fact_dp
